// File: rtl/pixel_burst_ctrl_pkg.sv
// Shared types and greyscale helper for the pixel burst engine and later colour blocks.
package pixel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } pbc_state_t;

  // Exact divide-by-three as multiply and shift; holds for channel sums below 2048.
  localparam int GREY_MUL = 683;
  localparam int GREY_SHR = 11;

  // Greyscale from three channels, each zero-extended to 16 bits by the caller.
  function automatic logic [15:0] grey_rgb(input logic [15:0] r,
                                           input logic [15:0] g,
                                           input logic [15:0] b,
                                           input bit exact);
    logic [31:0] s;
    logic [31:0] res;
    s = 32'(r) + 32'(g) + 32'(b);
    if (exact) res = (s * 32'(GREY_MUL)) >> GREY_SHR;
    else       res = (s >> 2) + (s >> 4) + (s >> 6) + (s >> 8);
    return res[15:0];
  endfunction

endpackage

// File: rtl/pixel_burst_ctrl_if.sv
// SRAM bus between the burst engine (master) and the SRAM model/controller (slave).
interface pixel_burst_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] r_data;
  logic              read_enable;
  logic              write_enable;

  modport master (output address, w_data, read_enable, write_enable, input r_data);
  modport slave  (input address, w_data, read_enable, write_enable, output r_data);
endinterface

// File: rtl/pixel_burst_ctrl_grey_conv.sv
// Combinational greyscale converter for one SRAM word.
// Build option: PIXEL_BURST_GREY_EXACT_EN selects exact floor(sum/3) instead of the shift-sum approximation.
module pixel_grey_conv
  import pixel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int CH    = 3
) (
  input  logic [CH*PIX_W-1:0] pix_in,
  output logic [PIX_W-1:0]    grey_out
);

  generate
    if (CH == 3) begin : g_rgb
`ifdef PIXEL_BURST_GREY_EXACT_EN
      localparam bit EXACT = 1'b1;
`else
      localparam bit EXACT = 1'b0;
`endif
      // R sits in the top channel, B in the bottom one.
      assign grey_out = PIX_W'(grey_rgb(16'(pix_in[3*PIX_W-1:2*PIX_W]),
                                        16'(pix_in[2*PIX_W-1:PIX_W]),
                                        16'(pix_in[PIX_W-1:0]),
                                        EXACT));
    end else begin : g_pass
      assign grey_out = pix_in[PIX_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/pixel_burst_ctrl.sv
// SRAM pixel burst engine: reads a greyscale burst into rd_pix, then writes wr_pix back out.
// Build option: PIXEL_BURST_GREY_EXACT_EN (exact greyscale conversion, see pixel_grey_conv).
module pixel_burst_ctrl
  import pixel_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int PIX_W     = 8,
  parameter int CH        = 3,
  parameter int MAX_BURST = 20,
  parameter int WAIT_CYC  = 4,
  parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          rd_base,
  input  logic [ADDR_W-1:0]          wr_base,
  input  logic [LEN_W-1:0]           rd_len,
  input  logic [LEN_W-1:0]           wr_len,
  input  logic [MAX_BURST*PIX_W-1:0] wr_pix,
  output logic [MAX_BURST*PIX_W-1:0] rd_pix,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  pixel_burst_ctrl_if.master         sram
);

  generate
    if (CH != 1 && CH != 3) begin : g_bad_ch
      $error("pixel_burst_ctrl: CH must be 1 or 3");
    end
    if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait
      $error("pixel_burst_ctrl: WAIT_CYC must be in 1..15");
    end
  endgenerate

  pbc_state_t state, state_d;

  logic [LEN_W-1:0]  idx;
  logic [3:0]        wcnt;
  logic [ADDR_W-1:0] rd_base_q, wr_base_q;
  logic [LEN_W-1:0]  rd_len_q, wr_len_q;
  logic              err_q;

  logic [MAX_BURST-1:0][PIX_W-1:0] rd_buf;
  logic [MAX_BURST-1:0][PIX_W-1:0] wr_arr;
  logic [PIX_W-1:0]                grey_pix;

  logic start_bad, start_ok, beat_end, last_rd, last_wr;
  logic [ADDR_W-1:0]   addr_c;
  logic [CH*PIX_W-1:0] wdata_c;
  logic                re_c, we_c;

  assign wr_arr = wr_pix;
  assign rd_pix = rd_buf;

  assign start_bad = start && ((rd_len > LEN_W'(MAX_BURST)) || (wr_len > LEN_W'(MAX_BURST)));
  assign start_ok  = start && !start_bad;
  assign beat_end  = (wcnt == 4'(WAIT_CYC - 1));
  assign last_rd   = beat_end && (idx == rd_len_q - LEN_W'(1));
  assign last_wr   = beat_end && (idx == wr_len_q - LEN_W'(1));

  pixel_grey_conv #(
    .PIX_W (PIX_W),
    .CH    (CH)
  ) u_grey (
    .pix_in   (sram.r_data),
    .grey_out (grey_pix)
  );

  // State register; reset abandons any burst in progress.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state and SRAM strobe/address decode from the registered state.
  always_comb begin
    state_d = state;
    addr_c  = '0;
    wdata_c = '0;
    re_c    = 1'b0;
    we_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          if (rd_len != '0)      state_d = ST_READ;
          else if (wr_len != '0) state_d = ST_WRITE;
          else                   state_d = ST_DONE;
        end
      end
      ST_READ: begin
        addr_c = rd_base_q + ADDR_W'(idx);
        re_c   = 1'b1;
        if (last_rd) state_d = (wr_len_q != '0) ? ST_WRITE : ST_DONE;
      end
      ST_WRITE: begin
        addr_c  = wr_base_q + ADDR_W'(idx);
        we_c    = 1'b1;
        wdata_c = {CH{wr_arr[idx]}};
        if (last_wr) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst bookkeeping: latch the request, pace each pixel over WAIT_CYC cycles, capture reads.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx       <= '0;
      wcnt      <= '0;
      rd_base_q <= '0;
      wr_base_q <= '0;
      rd_len_q  <= '0;
      wr_len_q  <= '0;
      err_q     <= 1'b0;
      rd_buf    <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_bad) begin
            err_q <= 1'b1;
          end else if (start) begin
            rd_base_q <= rd_base;
            wr_base_q <= wr_base;
            rd_len_q  <= rd_len;
            wr_len_q  <= wr_len;
            idx       <= '0;
            wcnt      <= '0;
          end
        end
        ST_READ: begin
          if (beat_end) begin
            rd_buf[idx] <= grey_pix;
            wcnt        <= '0;
            idx         <= last_rd ? '0 : idx + LEN_W'(1);
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        ST_WRITE: begin
          if (beat_end) begin
            wcnt <= '0;
            idx  <= last_wr ? '0 : idx + LEN_W'(1);
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign err  = err_q;

  assign sram.address      = addr_c;
  assign sram.w_data       = wdata_c;
  assign sram.read_enable  = re_c;
  assign sram.write_enable = we_c;

endmodule

// File: doc/pixel_burst_ctrl.md
Name: pixel_burst_ctrl

Overview:
- Parametrised SRAM pixel burst engine for the edge-detection datapath.
- On `start`, reads a burst of RGB words from SRAM, converts each to greyscale and buffers them on `rd_pix` for the filter core.
- Then writes a burst of filter-result pixels from `wr_pix` back to SRAM, and reports `done`.
- Sits between the filter core and the SRAM model/controller, under the top-level sequencer.

Parameters:
- ADDR_W, 16, SRAM address width.
- PIX_W, 8, bits per colour channel and per grey pixel.
- CH, 3, channels per SRAM word; legal values 1 (passthrough) or 3 (RGB); any other value is an elaboration error.
- MAX_BURST, 20, depth of the read buffer and of the write vector.
- WAIT_CYC, 4, clock cycles per SRAM access (range 1..15).
- LEN_W, $clog2(MAX_BURST+1), width of the length inputs.

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- rd_base  in  ADDR_W  first read address.
- wr_base  in  ADDR_W  first write address.
- rd_len  in  LEN_W  pixels to read (0..MAX_BURST).
- wr_len  in  LEN_W  pixels to write (0..MAX_BURST).
- wr_pix  in  MAX_BURST*PIX_W  pixels to write; element i goes to wr_base+i.
- rd_pix  out  MAX_BURST*PIX_W  greyscale read buffer; element i comes from rd_base+i.
- busy  out  1  high in READ, WRITE and DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on a rejected start.
- address  out  ADDR_W  SRAM address.
- w_data  out  CH*PIX_W  SRAM write data.
- r_data  in  CH*PIX_W  SRAM read data.
- read_enable  out  1  SRAM read strobe.
- write_enable  out  1  SRAM write strobe.

Behaviour:
- Reset: state=IDLE; all counters 0; rd_pix all 0; address 0 (never Z); w_data 0; read_enable, write_enable, busy, done, err all 0.
- States: IDLE, READ, WRITE, DONE.
- Registers: pixel index idx (LEN_W bits) and wait counter wcnt (4 bits).
- IDLE:
  - start=1 with rd_len>MAX_BURST or wr_len>MAX_BURST: err=1 for the next cycle; stay in IDLE.
  - start=1 otherwise: latch rd_base, wr_base, rd_len, wr_len; set idx=0, wcnt=0.
  - Next state: READ if rd_len≠0; else WRITE if wr_len≠0; else DONE.
- READ:
  - Outputs: address = rd_base+idx (mod 2^ADDR_W); read_enable=1; write_enable=0.
  - wcnt increments every cycle.
  - When wcnt==WAIT_CYC-1: rd_pix[idx] <= grey(r_data); wcnt <= 0; idx <= idx+1.
  - When that capture is for idx==rd_len-1: idx <= 0; go to WRITE if wr_len≠0, else DONE.
- WRITE:
  - Outputs: address = wr_base+idx (mod 2^ADDR_W); write_enable=1; read_enable=0.
  - w_data = wr_pix[idx] replicated across all CH channels.
  - Same wcnt/idx stepping as READ; after idx==wr_len-1 completes, go to DONE.
- DONE: done=1 for exactly one cycle; strobes 0; next state IDLE.
- Strobes and address are decoded from registered state. Each pixel occupies exactly WAIT_CYC consecutive cycles with address stable.
- Latency: start sampled at cycle T → done high at cycle T+1+(rd_len+wr_len)*WAIT_CYC.
- grey(), CH=3:
  - s = R+G+B, computed PIX_W+2 bits wide.
  - g = (s>>2)+(s>>4)+(s>>6)+(s>>8), truncated to PIX_W.
  - Channel order: R in the top PIX_W bits, B in the bottom.
- grey(), CH=1: g = r_data.
- rd_pix entries at idx ≥ rd_len keep their previous values. The whole buffer holds until overwritten by a later READ.
- start while busy: ignored.
- n_rst asserted mid-burst: immediate return to the reset state; any partial burst is abandoned.
- wr_pix and r_data are not registered; the upstream block holds wr_pix stable while busy.

Optional Feature:
- Macro: PIXEL_BURST_GREY_EXACT_EN.
- Defined: for CH=3, g = floor(s/3), exact (implementation: s*683>>11, valid for s<2048).
- Undefined: the shift-sum approximation above.
- CH=1 is unaffected either way.

Decomposition:
- Package pixel_pkg holds:
  - the state enum (pbc_state_t);
  - constants GREY_MUL=683 and GREY_SHR=11;
  - a function grey_rgb(), shared with later colour blocks.
- One sub-module, pixel_grey_conv: combinational, CH*PIX_W in → PIX_W out, macro-aware. Instantiated once in READ capture.

Test Plan:
- Reset mid-READ (rd_len=5, after 6 cycles) → address=0, strobes 0, busy 0, rd_pix all 0; a fresh start then runs normally.
- WAIT_CYC=4, rd_base=16'h0100, rd_len=2; r_data={8'd255,8'd255,8'd255} → read_enable high for 8 cycles at addresses 0x0100 then 0x0101; rd_pix[0]=251 (exact: 255); done at T+9.
- r_data={8'd30,8'd60,8'd90}, rd_len=1, wr_len=0 → rd_pix[0]=58 (exact: 60); no write_enable ever; done at T+5.
- wr_base=16'hFFFF, wr_len=2, rd_len=0, wr_pix[0]=8'hAA, wr_pix[1]=8'h55 → writes to FFFF (w_data=24'hAAAAAA), then 0000 (24'h555555), 4 cycles each.
- rd_len=21 (MAX_BURST=20) → err pulse for 1 cycle, busy stays 0, no strobes.
- rd_len=0, wr_len=0 → done at T+1; start pulsed again while busy during a long burst → ignored, exactly one done.
